sram_request_port: RTL and testbench

- Initiator-side controller for the single-port TSMC-style SRAM macro.
- Converts a valid/ready request stream (reads and masked writes) into macro pin activity: CEB, WEB, A, D, M.
- Returns read data on a valid/ready response stream. Handles the macro's 1-cycle read latency and response backpressure with credit-limited buffering.
- Sits between a datapath client (e.g. weight or state fetch logic) and one SRAM instance.

---
 rtl/sram_request_port.sv | 122 ++++++++++++
 tb/tb_sram_request_port.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_request_port.sv
// sram_request_port: initiator-side controller for a single-port SRAM macro.
// Turns a valid/ready request stream into macro pin activity. Read data comes
// back on a valid/ready response stream. The macro has a one-cycle read
// latency, and a small fall-through buffer absorbs response backpressure.
// Reads are only issued while a buffer slot is guaranteed to be free, so the
// buffer can never overflow.
module sram_request_port #(
    parameter int WIDTH        = 128,
    parameter int NUM_ROWS     = 4096,
    parameter int RSP_DEPTH    = 2,
    localparam int AddressWidth = $clog2(NUM_ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [WIDTH-1:0]        req_data,
    input  logic [WIDTH-1:0]        req_bit_en,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    sram_ceb,
    output logic                    sram_web,
    output logic [AddressWidth-1:0] sram_a,
    output logic [WIDTH-1:0]        sram_d,
    output logic [WIDTH-1:0]        sram_m,
    input  logic [WIDTH-1:0]        sram_q
);

    localparam int CountWidth = $clog2(RSP_DEPTH + 1);
    localparam int PtrWidth   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int OccWidth   = CountWidth + 1;

    logic                  fire;
    logic                  read_fire;
    logic                  inflight;
    logic [CountWidth-1:0] fifo_count;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [WIDTH-1:0]      fifo_mem [RSP_DEPTH];
    logic [OccWidth-1:0]   occupancy;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RSP_DEPTH - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Credit: buffered entries plus the read whose data is on sram_q this cycle.
    // Writes produce no response, so they are never held back.
    assign occupancy  = OccWidth'(fifo_count) + OccWidth'(inflight);
    assign req_ready  = req_write | (occupancy < OccWidth'(RSP_DEPTH));

    // rst_n gates the handshake so the macro stays idle while reset is held.
    assign fire       = req_valid & req_ready & rst_n;
    assign read_fire  = fire & ~req_write;

    assign sram_ceb   = ~fire;
    assign sram_web   = ~(fire & req_write);
    assign sram_a     = req_addr;
    assign sram_d     = req_data;
    assign sram_m     = ~req_bit_en;

    assign fifo_empty = (fifo_count == '0);
    assign rsp_valid  = ~fifo_empty | inflight;

    // Store the macro output unless it is consumed straight through the bypass.
    assign push       = inflight & ~(fifo_empty & rsp_ready);
    assign pop        = ~fifo_empty & rsp_ready;

    // Response mux: buffered head first, then the bypassed macro output, else zero.
    always_comb begin
        rsp_data = '0;
        if (!fifo_empty) begin
            rsp_data = fifo_mem[rd_ptr];
        end else if (inflight) begin
            rsp_data = sram_q;
        end
    end

    // Track the one-cycle macro read latency; a read in flight is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_fire;
        end
    end

    // Buffer bookkeeping: occupancy count and wrapping read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CountWidth'(1);
                2'b01:   fifo_count <= fifo_count - CountWidth'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Buffer storage: contents need no reset because the count marks validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_q;
        end
    end

endmodule

// File: tb/tb_sram_request_port.sv
// tb_sram_request_port: self-checking bench for sram_request_port with a
// behavioural SRAM macro, a reference memory and an in-order response scoreboard.
module tb_sram_request_port;

    localparam int W  = 128;
    localparam int AW = 12;
    localparam int NR = 4096;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic [W-1:0]  req_bit_en;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_m;
    logic [W-1:0]  sram_q;

    logic [W-1:0]  sram_mem [NR];
    logic [W-1:0]  ref_mem  [NR];
    logic [W-1:0]  sb [$];

    int checks;
    int failures;

    localparam logic [W-1:0] Ones = {W{1'b1}};

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  ben;
        logic          exp_ready;
        logic          exp_ceb;
        logic          exp_web;
        logic [W-1:0]  exp_m;
    } vec_t;

    vec_t vecs [6];

    sram_request_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_bit_en (req_bit_en),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_m     (sram_m),
        .sram_q     (sram_q)
    );

    function automatic logic [W-1:0] initWord(input int i);
        return {32'(i) ^ 32'h1234_5678, 32'hCAFE_0000 | 32'(i), ~32'(i), 32'h0F0F_0000 + 32'(i)};
    endfunction

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro contents start from a known pattern.
    initial begin
        for (int i = 0; i < NR; i++) begin
            sram_mem[i] <= initWord(i);
        end
        sram_q <= '0;
    end

    // Behavioural macro: masked write, one-cycle read, garbage on q otherwise.
    always @(posedge clk) begin
        if (!sram_ceb && !sram_web) begin
            sram_mem[sram_a] <= (sram_mem[sram_a] & sram_m) | (sram_d & ~sram_m);
        end
        if (!sram_ceb && sram_web) begin
            sram_q <= sram_mem[sram_a];
        end else begin
            sram_q <= {4{$urandom()}};
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] addr,
                                 input logic [W-1:0] data, input logic [W-1:0] ben, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_addr   = addr;
        req_data   = data;
        req_bit_en = ben;
        rsp_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard: compare responses in order, then record this cycle's request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected actual=%h expected=no_response", rsp_data);
                end else begin
                    checkOutput("sb_rsp_data", rsp_data, sb.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    ref_mem[req_addr] = (ref_mem[req_addr] & ~req_bit_en) | (req_data & req_bit_en);
                end else begin
                    sb.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    // Reads in flight or buffered at reset never come back.
    always @(negedge rst_n) begin
        sb.delete();
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NR; i++) begin
            ref_mem[i] = initWord(i);
        end

        vecs[0] = '{1'b0, 1'b0, 12'd50,   Ones,           Ones,                   1'b1, 1'b1, 1'b1, '0};
        vecs[1] = '{1'b1, 1'b1, 12'd100,  {4{32'h1357_9BDF}}, Ones,               1'b1, 1'b0, 1'b0, '0};
        vecs[2] = '{1'b1, 1'b0, 12'd100,  '0,             '0,                     1'b1, 1'b0, 1'b1, Ones};
        vecs[3] = '{1'b1, 1'b1, 12'd101,  Ones,           {64'h0, {64{1'b1}}},    1'b1, 1'b0, 1'b0, {{64{1'b1}}, 64'h0}};
        vecs[4] = '{1'b0, 1'b1, 12'd101,  Ones,           Ones,                   1'b1, 1'b1, 1'b1, '0};
        vecs[5] = '{1'b1, 1'b0, 12'd4095, '0,             Ones,                   1'b1, 1'b0, 1'b1, '0};

        // Reset state, with a request presented while reset is held.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 12'd3, '0, '0, 1'b1);
        sample();
        checkOutput("rst_ceb",       W'(sram_ceb),  W'(1'b1));
        checkOutput("rst_web",       W'(sram_web),  W'(1'b1));
        checkOutput("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        checkOutput("rst_rsp_data",  rsp_data,      '0);
        checkOutput("rst_req_ready", W'(req_ready), W'(1'b1));
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();

        // Table-driven issue-path vectors.
        for (int k = 0; k < 6; k++) begin
            tick();
            applyStimulus(vecs[k].v, vecs[k].w, vecs[k].addr, vecs[k].data, vecs[k].ben, 1'b1);
            sample();
            checkOutput($sformatf("vec%0d_ready", k), W'(req_ready), W'(vecs[k].exp_ready));
            checkOutput($sformatf("vec%0d_ceb", k),   W'(sram_ceb),  W'(vecs[k].exp_ceb));
            checkOutput($sformatf("vec%0d_web", k),   W'(sram_web),  W'(vecs[k].exp_web));
            checkOutput($sformatf("vec%0d_a", k),     W'(sram_a),    W'(vecs[k].addr));
            checkOutput($sformatf("vec%0d_d", k),     sram_d,        vecs[k].data);
            checkOutput($sformatf("vec%0d_m", k),     sram_m,        vecs[k].exp_m);
        end
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        tick();

        // Masked write then readback, one-cycle response latency.
        applyStimulus(1'b1, 1'b1, 12'd5, Ones, Ones, 1'b1);
        sample();
        checkOutput("t1_w1_ceb", W'(sram_ceb), W'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b1, 12'd5, '0, {{120{1'b0}}, 8'hFF}, 1'b1);
        sample();
        checkOutput("t1_w2_m", sram_m, {{120{1'b1}}, 8'h00});
        tick();
        applyStimulus(1'b1, 1'b0, 12'd5, '0, '0, 1'b1);
        sample();
        checkOutput("t1_rd_valid_early", W'(rsp_valid), W'(1'b0));
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t1_rd_valid", W'(rsp_valid), W'(1'b1));
        checkOutput("t1_rd_data",  rsp_data, {{120{1'b1}}, 8'h00});
        tick();
        sample();
        checkOutput("t1_rd_valid_after", W'(rsp_valid), W'(1'b0));

        // Throughput: eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            tick();
            applyStimulus(1'b1, 1'b0, 12'(i), '0, '0, 1'b1);
            sample();
            checkOutput($sformatf("t2_ready%0d", i), W'(req_ready), W'(1'b1));
            if (i > 0) begin
                checkOutput($sformatf("t2_valid%0d", i), W'(rsp_valid), W'(1'b1));
                checkOutput($sformatf("t2_data%0d", i), rsp_data, ref_mem[i-1]);
            end
        end
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t2_valid8", W'(rsp_valid), W'(1'b1));
        checkOutput("t2_data8",  rsp_data, ref_mem[7]);
        tick();

        // Backpressure: two reads accepted, third held, write still accepted.
        applyStimulus(1'b1, 1'b0, 12'd1, '0, '0, 1'b0);
        sample();
        checkOutput("t3_ready_a", W'(req_ready), W'(1'b1));
        tick();
        applyStimulus(1'b1, 1'b0, 12'd2, '0, '0, 1'b0);
        sample();
        checkOutput("t3_ready_b", W'(req_ready), W'(1'b1));
        tick();
        applyStimulus(1'b1, 1'b0, 12'd3, '0, '0, 1'b0);
        sample();
        checkOutput("t3_ready_c", W'(req_ready), W'(1'b0));
        checkOutput("t3_ceb_c",   W'(sram_ceb),  W'(1'b1));
        tick();
        applyStimulus(1'b1, 1'b1, 12'd20, {4{32'hDEAD_BEEF}}, Ones, 1'b0);
        sample();
        checkOutput("t3_wr_ready", W'(req_ready), W'(1'b1));
        checkOutput("t3_wr_ceb",   W'(sram_ceb),  W'(1'b0));
        checkOutput("t3_wr_web",   W'(sram_web),  W'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 12'd3, '0, '0, 1'b0);
        sample();
        checkOutput("t3_ready_e", W'(req_ready), W'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 12'd3, '0, '0, 1'b1);
        sample();
        checkOutput("t3_ready_f", W'(req_ready), W'(1'b0));
        checkOutput("t3_data_1",  rsp_data, ref_mem[1]);
        tick();
        sample();
        checkOutput("t3_ready_g", W'(req_ready), W'(1'b1));
        checkOutput("t3_data_2",  rsp_data, ref_mem[2]);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t3_valid_3", W'(rsp_valid), W'(1'b1));
        checkOutput("t3_data_3",  rsp_data, ref_mem[3]);

        // Idle: macro quiet, no responses.
        for (int i = 0; i < 10; i++) begin
            tick();
            sample();
            checkOutput($sformatf("t4_ceb%0d", i),   W'(sram_ceb),  W'(1'b1));
            checkOutput($sformatf("t4_web%0d", i),   W'(sram_web),  W'(1'b1));
            checkOutput($sformatf("t4_valid%0d", i), W'(rsp_valid), W'(1'b0));
        end

        // Reset with one entry buffered and one read in flight.
        tick();
        applyStimulus(1'b1, 1'b0, 12'd1, '0, '0, 1'b0);
        sample();
        tick();
        applyStimulus(1'b1, 1'b0, 12'd2, '0, '0, 1'b0);
        sample();
        tick();
        applyStimulus(1'b1, 1'b0, 12'd3, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", W'(rsp_valid), W'(1'b0));
        checkOutput("t5_async_ceb",   W'(sram_ceb),  W'(1'b1));
        checkOutput("t5_async_data",  rsp_data, '0);
        checkOutput("t5_async_ready", W'(req_ready), W'(1'b1));
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t5_post_valid", W'(rsp_valid), W'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b0, 12'd7, '0, '0, 1'b1);
        sample();
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t5_new_valid", W'(rsp_valid), W'(1'b1));
        checkOutput("t5_new_data",  rsp_data, ref_mem[7]);
        for (int i = 0; i < 2; i++) begin
            tick();
            sample();
            checkOutput($sformatf("t5_no_stale%0d", i), W'(rsp_valid), W'(1'b0));
        end

        // Write immediately followed by read of the same row.
        tick();
        applyStimulus(1'b1, 1'b1, 12'd9, {16{8'hA5}}, Ones, 1'b1);
        sample();
        tick();
        applyStimulus(1'b1, 1'b0, 12'd9, '0, '0, 1'b1);
        sample();
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        sample();
        checkOutput("t6_valid", W'(rsp_valid), W'(1'b1));
        checkOutput("t6_data",  rsp_data, {16{8'hA5}});

        tick();
        sample();
        checkOutput("sb_drained", W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
